// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_PORTS requesters.
// Each grant latches one request, holds it until dmem_ready_i or the bus timeout.
module dmem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_PORTS-1:0]                     s_valid_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]          s_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]          s_wdata_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]      s_we_i,
  output logic [NUM_PORTS-1:0]                     s_ready_o,
  output logic [NUM_PORTS-1:0]                     s_err_o,
  output logic [DATA_WIDTH-1:0]                    s_rdata_o,
  output logic                                     dmem_valid_o,
  input  logic                                     dmem_ready_i,
  output logic [ADDR_WIDTH-1:0]                    dmem_addr_o,
  output logic [DATA_WIDTH-1:0]                    dmem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                  dmem_we_o,
  input  logic [DATA_WIDTH-1:0]                    dmem_rdata_i,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_o,
  output logic                                     busy_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant;
  logic [TW-1:0] timer;

  logic          pick_found;
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  int unsigned   idx;
  logic          done;
  logic          timeout_hit;

  // First requester at or above rr_ptr, wrapping around to port 0.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = GW'(idx);
      if (!pick_found && s_valid_i[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  assign done        = (state == BUSY) && dmem_ready_i;
  assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && !dmem_ready_i && (timer == T_LAST);

  always_comb begin
    state_next = state;
    s_ready_o  = '0;
    s_err_o    = '0;
    s_rdata_o  = '0;
    case (state)
      IDLE: if (pick_found) state_next = BUSY;
      BUSY: begin
        // Ready wins over a coincident timeout: normal completion, no error.
        if (done) begin
          s_ready_o[grant] = 1'b1;
          s_rdata_o        = dmem_rdata_i;
          state_next       = IDLE;
        end else if (timeout_hit) begin
          s_ready_o[grant] = 1'b1;
          s_err_o[grant]   = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      timer        <= '0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_we_o    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (pick_found) begin
          grant        <= pick;
          timer        <= '0;
          dmem_addr_o  <= s_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
          dmem_wdata_o <= s_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
          dmem_we_o    <= s_we_i[pick*BW +: BW];
        end
      end else if (done || timeout_hit) begin
        rr_ptr <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
        timer  <= '0;
      end else if (TIMEOUT > 0) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign dmem_valid_o = (state == BUSY);
  assign busy_o       = (state == BUSY);
  assign grant_o      = grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (2 ports, 32-bit, TIMEOUT=4).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_valid_i;
  logic [63:0] s_addr_i;
  logic [63:0] s_wdata_i;
  logic [7:0]  s_we_i;
  logic [1:0]  s_ready_o;
  logic [1:0]  s_err_o;
  logic [31:0] s_rdata_o;
  logic        dmem_valid_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_we_o;
  logic [31:0] dmem_rdata_i;
  logic [0:0]  grant_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(
    .NUM_PORTS (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid_i   (s_valid_i),
    .s_addr_i    (s_addr_i),
    .s_wdata_i   (s_wdata_i),
    .s_we_i      (s_we_i),
    .s_ready_o   (s_ready_o),
    .s_err_o     (s_err_o),
    .s_rdata_o   (s_rdata_o),
    .dmem_valid_o(dmem_valid_o),
    .dmem_ready_i(dmem_ready_i),
    .dmem_addr_o (dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_rdata_i(dmem_rdata_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    s_valid_i    = '0;
    s_addr_i     = '0;
    s_wdata_i    = '0;
    s_we_i       = '0;
    dmem_ready_i = 1'b0;
    dmem_rdata_i = '0;

    // 1: reset, then idle
    cyc(); cyc();
    mid();
    chk("rst_valid", dmem_valid_o, 1'b0);
    chk("rst_addr",  dmem_addr_o, 32'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_we",    dmem_we_o, 4'h0);
    chk("rst_ready", s_ready_o, 2'b00);
    chk("rst_err",   s_err_o, 2'b00);
    chk("rst_rdata", s_rdata_o, 32'h0);
    chk("rst_grant", grant_o, 1'b0);
    chk("rst_busy",  busy_o, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dmem_ready_i = (i == 5);
      dmem_rdata_i = 32'h1111_2222;
      mid();
      chk("idle_valid", dmem_valid_o, 1'b0);
      chk("idle_sready", s_ready_o, 2'b00);
      cyc();
    end
    dmem_ready_i = 1'b0;

    // 2: single read from port 1, ready on third BUSY cycle
    s_valid_i      = 2'b10;
    s_addr_i[63:32] = 32'h0000_0100;
    s_we_i         = '0;
    mid();
    chk("rd_idle_valid", dmem_valid_o, 1'b0);
    cyc();
    s_valid_i = 2'b00;
    mid();
    chk("rd_b1_valid", dmem_valid_o, 1'b1);
    chk("rd_b1_addr",  dmem_addr_o, 32'h100);
    chk("rd_b1_grant", grant_o, 1'b1);
    chk("rd_b1_busy",  busy_o, 1'b1);
    chk("rd_b1_ready", s_ready_o, 2'b00);
    cyc();
    mid();
    chk("rd_b2_ready", s_ready_o, 2'b00);
    cyc();
    dmem_ready_i = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    mid();
    chk("rd_b3_ready", s_ready_o, 2'b10);
    chk("rd_b3_rdata", s_rdata_o, 32'hDEAD_BEEF);
    chk("rd_b3_err",   s_err_o, 2'b00);
    cyc();
    dmem_ready_i = 1'b0;
    mid();
    chk("rd_after_valid", dmem_valid_o, 1'b0);
    chk("rd_after_ready", s_ready_o, 2'b00);
    chk("rd_after_grant", grant_o, 1'b1);

    // 3: contention, both ports always valid, ready in first BUSY cycle
    s_valid_i      = 2'b11;
    s_addr_i[31:0] = 32'h0000_0A00;
    s_addr_i[63:32] = 32'h0000_0B00;
    for (int k = 0; k < 4; k++) begin
      cyc();
      dmem_ready_i = 1'b1;
      mid();
      chk("arb_grant", grant_o, (k % 2 == 0) ? 1'b0 : 1'b1);
      chk("arb_ready", s_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("arb_addr",  dmem_addr_o, (k % 2 == 0) ? 32'hA00 : 32'hB00);
      cyc();
      dmem_ready_i = 1'b0;
      mid();
      chk("arb_dead_valid", dmem_valid_o, 1'b0);
    end
    s_valid_i = 2'b00;
    cyc();

    // 4: write latch on port 0, inputs change while BUSY
    s_valid_i       = 2'b01;
    s_addr_i[31:0]  = 32'h0000_0040;
    s_wdata_i[31:0] = 32'h1234_5678;
    s_we_i[3:0]     = 4'b0011;
    cyc();
    s_valid_i       = 2'b00;
    s_wdata_i[31:0] = 32'hFFFF_FFFF;
    s_we_i[3:0]     = 4'b1111;
    s_addr_i[31:0]  = 32'h0000_0999;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) dmem_ready_i = 1'b1;
      mid();
      chk("wr_wdata", dmem_wdata_o, 32'h1234_5678);
      chk("wr_we",    dmem_we_o, 4'b0011);
      chk("wr_addr",  dmem_addr_o, 32'h40);
      chk("wr_ready", s_ready_o, (k == 2) ? 2'b01 : 2'b00);
      cyc();
    end
    dmem_ready_i = 1'b0;
    mid();
    chk("wr_after_valid", dmem_valid_o, 1'b0);

    // 5a: timeout; rr_ptr=1, only port 0 requests so the scan wraps
    s_valid_i    = 2'b01;
    dmem_rdata_i = 32'hCAFE_F00D;
    cyc();
    s_valid_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("to_grant", grant_o, 1'b0);
      chk("to_ready", s_ready_o, (k == 3) ? 2'b01 : 2'b00);
      chk("to_err",   s_err_o,   (k == 3) ? 2'b01 : 2'b00);
      if (k == 3) chk("to_rdata", s_rdata_o, 32'h0);
      cyc();
    end
    mid();
    chk("to_after_valid", dmem_valid_o, 1'b0);
    chk("to_after_ready", s_ready_o, 2'b00);

    // 5b: ready coincides with the timeout cycle -> no error
    s_valid_i = 2'b10;
    cyc();
    s_valid_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h55AA_55AA;
      end
      mid();
      chk("tr_ready", s_ready_o, (k == 3) ? 2'b10 : 2'b00);
      chk("tr_err",   s_err_o, 2'b00);
      cyc();
    end
    dmem_ready_i = 1'b0;
    mid();
    chk("tr_after_valid", dmem_valid_o, 1'b0);

    // 6: advance rr_ptr to 1, then reset mid-transaction
    s_valid_i = 2'b01;
    cyc();
    s_valid_i    = 2'b00;
    dmem_ready_i = 1'b1;
    mid();
    chk("rm_pre_ready", s_ready_o, 2'b01);
    cyc();
    dmem_ready_i = 1'b0;
    s_valid_i    = 2'b10;
    s_addr_i[63:32] = 32'h0000_0777;
    cyc();
    s_valid_i = 2'b00;
    mid();
    chk("rm_b1_grant", grant_o, 1'b1);
    cyc();
    rst = 1'b1;
    mid();
    chk("rm_b2_ready", s_ready_o, 2'b00);
    cyc();
    rst = 1'b0;
    mid();
    chk("rm_post_valid", dmem_valid_o, 1'b0);
    chk("rm_post_ready", s_ready_o, 2'b00);
    chk("rm_post_err",   s_err_o, 2'b00);
    chk("rm_post_grant", grant_o, 1'b0);
    chk("rm_post_addr",  dmem_addr_o, 32'h0);
    s_valid_i = 2'b11;
    cyc();
    s_valid_i = 2'b00;
    dmem_ready_i = 1'b1;
    mid();
    chk("rm_next_grant", grant_o, 1'b0);
    chk("rm_next_ready", s_ready_o, 2'b01);
    cyc();
    dmem_ready_i = 1'b0;
    mid();
    chk("rm_end_valid", dmem_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
